// File: rtl/xpb_accum.sv
// Runtime-loadable xpb residue accumulator: one digit per clock, each digit
// selects an entry from its own writable table, summed at full precision.
module xpb_accum #(
  parameter int unsigned WORD_BITS  = 1024,
  parameter int unsigned DIGIT_BITS = 5,
  parameter int unsigned NUM_DIGITS = 4,
  localparam int unsigned SUM_BITS  = WORD_BITS + $clog2(NUM_DIGITS) + 1,
  localparam int unsigned CNT_BITS  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_we,
  input  logic [CNT_BITS-1:0]              cfg_digit,
  input  logic [DIGIT_BITS-1:0]            cfg_idx,
  input  logic [WORD_BITS-1:0]             cfg_data,
  input  logic                             start,
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0] data_in,
  output logic                             busy,
  output logic                             done,
  output logic [SUM_BITS-1:0]              sum_out
);

  localparam int unsigned ENTRIES = 1 << DIGIT_BITS;
  localparam int unsigned OP_BITS = NUM_DIGITS * DIGIT_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_n;
  logic                  load;
  logic                  step;
  logic                  last;
  logic                  tbl_we;
  logic [OP_BITS-1:0]    op;
  logic [CNT_BITS-1:0]   cnt;
  logic [SUM_BITS-1:0]   acc;
  logic [SUM_BITS-1:0]   acc_n;
  logic [WORD_BITS-1:0]  entry;
  logic [DIGIT_BITS-1:0] digits [NUM_DIGITS];
  logic [WORD_BITS-1:0]  tbl    [NUM_DIGITS][ENTRIES];

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign digits[k] = op[k*DIGIT_BITS +: DIGIT_BITS];
  end

  // Entry 0 is never stored; it always reads as zero and writes to it are ignored.
  assign tbl_we = cfg_we && (state == IDLE) && (cfg_idx != '0) &&
                  (32'(cfg_digit) < NUM_DIGITS);

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl[cfg_digit][cfg_idx] <= cfg_data;
    end
  end

  assign entry = (digits[cnt] == '0) ? '0 : tbl[cnt][digits[cnt]];
  assign acc_n = acc + SUM_BITS'(entry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_BITS'(NUM_DIGITS - 1)) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, accumulation and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op      <= '0;
      cnt     <= '0;
      acc     <= '0;
      sum_out <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= (state_n == DONE);
      busy <= (state_n != IDLE);
      if (load) begin
        op  <= data_in;
        acc <= '0;
        cnt <= '0;
      end
      if (step) begin
        acc <= acc_n;
        cnt <= cnt + CNT_BITS'(1);
      end
      if (last) begin
        sum_out <= acc_n;
      end
    end
  end

endmodule
